// File: rtl/ball_collision_referee.sv
// Pong referee: turns ball/paddle geometry into one-cycle bounce strobes for the
// ball mover, runs the serve/play/goal/game-over rally loop and keeps the score.
module ball_collision_referee #(
    parameter int LEFT_PADDLE_X     = 20,
    parameter int RIGHT_PADDLE_X    = 220,
    parameter int PADDLE_HALF_WIDTH = 5,
    parameter int HIT_MARGIN        = 5,
    parameter int PADDLE_LENGTH     = 40,
    parameter int LEFT_GOAL_X       = 5,
    parameter int RIGHT_GOAL_X      = 235,
    parameter int SCREEN_X          = 240,
    parameter int SERVE_DELAY       = 50000000,
    parameter int WIN_SCORE         = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       startGame,
    input  logic [7:0] ballX,
    input  logic [8:0] ballY,
    input  logic       ballDirection,
    input  logic [8:0] leftPaddleY,
    input  logic [8:0] rightPaddleY,
    output logic       changeXDirection,
    output logic [1:0] changeYDirection,
    output logic       ballReset,
    output logic [3:0] scoreLeft,
    output logic [3:0] scoreRight,
    output logic       gameOver,
    output logic       winner,
    output logic [1:0] debug_state
);

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        GOAL      = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [7:0] L_HIT_X  = 8'(LEFT_PADDLE_X + PADDLE_HALF_WIDTH + HIT_MARGIN);
    localparam logic [7:0] R_HIT_X  = 8'(RIGHT_PADDLE_X - PADDLE_HALF_WIDTH - HIT_MARGIN);
    localparam logic [7:0] L_GOAL   = 8'(LEFT_GOAL_X);
    localparam logic [7:0] R_GOAL   = 8'(RIGHT_GOAL_X);
    localparam logic [7:0] SCREEN   = 8'(SCREEN_X);
    localparam logic [9:0] P_SPAN   = 10'(PADDLE_LENGTH - 1);
    localparam logic [9:0] P_HALF   = 10'(PADDLE_LENGTH / 2);
    localparam logic [3:0] WIN      = 4'(WIN_SCORE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       score_left_q, score_left_d;
    logic [3:0]       score_right_q, score_right_d;
    logic             change_x_q, change_x_d;
    logic [1:0]       change_y_q, change_y_d;
    logic             ball_reset_q, ball_reset_d;
    logic             game_over_q, game_over_d;
    logic             winner_q, winner_d;
    logic             lock_left_q, lock_left_d;
    logic             lock_right_q, lock_right_d;
    logic             scorer_q, scorer_d;

    // Y arithmetic is widened to 10 bits so a paddle near the bottom cannot wrap.
    logic [9:0] ball_y_w, left_top, right_top;
    logic       left_in_y, right_in_y, left_upper, right_upper;
    logic       left_hit, right_hit, left_goal, right_goal;
    logic [3:0] score_left_inc, score_right_inc;

    assign ball_y_w    = {1'b0, ballY};
    assign left_top    = {1'b0, leftPaddleY};
    assign right_top   = {1'b0, rightPaddleY};
    assign left_in_y   = (ball_y_w >= left_top) && (ball_y_w <= left_top + P_SPAN);
    assign right_in_y  = (ball_y_w >= right_top) && (ball_y_w <= right_top + P_SPAN);
    assign left_upper  = ball_y_w < left_top + P_HALF;
    assign right_upper = ball_y_w < right_top + P_HALF;

    assign left_hit  = !ballDirection && (ballX <= L_HIT_X) && (ballX > L_GOAL)
                       && left_in_y && !lock_left_q;
    assign right_hit = ballDirection && (ballX >= R_HIT_X) && (ballX < R_GOAL)
                       && right_in_y && !lock_right_q;
    // x at or above the screen width while moving left means the ball wrapped below 0.
    assign left_goal  = !ballDirection && ((ballX <= L_GOAL) || (ballX >= SCREEN));
    assign right_goal = ballDirection && (ballX >= R_GOAL);

    assign score_left_inc  = score_left_q + 4'd1;
    assign score_right_inc = score_right_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        change_x_d    = 1'b0;
        change_y_d    = 2'b00;
        ball_reset_d  = ball_reset_q;
        game_over_d   = game_over_q;
        winner_d      = winner_q;
        lock_left_d   = lock_left_q;
        lock_right_d  = lock_right_q;
        scorer_d      = scorer_q;

        // A lockout holds until the mover has actually reversed the ball.
        if (ballDirection) begin
            lock_left_d = 1'b0;
        end else begin
            lock_right_d = 1'b0;
        end

        case (state_q)
            SERVE: begin
                ball_reset_d = 1'b1;
                if (count_q == CNT_LAST) begin
                    count_d      = '0;
                    state_d      = PLAY;
                    ball_reset_d = 1'b0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            PLAY: begin
                ball_reset_d = 1'b0;
                if (left_goal || right_goal) begin
                    scorer_d     = left_goal;
                    state_d      = GOAL;
                    ball_reset_d = 1'b1;
                end else if (left_hit) begin
                    change_x_d  = 1'b1;
                    change_y_d  = left_upper ? 2'b10 : 2'b01;
                    lock_left_d = 1'b1;
                end else if (right_hit) begin
                    change_x_d   = 1'b1;
                    change_y_d   = right_upper ? 2'b10 : 2'b01;
                    lock_right_d = 1'b1;
                end
            end
            GOAL: begin
                ball_reset_d = 1'b1;
                lock_left_d  = 1'b0;
                lock_right_d = 1'b0;
                count_d      = '0;
                state_d      = SERVE;
                if (scorer_q) begin
                    score_right_d = score_right_inc;
                    if (score_right_inc == WIN) begin
                        state_d     = GAME_OVER;
                        game_over_d = 1'b1;
                        winner_d    = 1'b1;
                    end
                end else begin
                    score_left_d = score_left_inc;
                    if (score_left_inc == WIN) begin
                        state_d     = GAME_OVER;
                        game_over_d = 1'b1;
                        winner_d    = 1'b0;
                    end
                end
            end
            GAME_OVER: begin
                ball_reset_d = 1'b1;
                if (startGame) begin
                    score_left_d  = 4'd0;
                    score_right_d = 4'd0;
                    game_over_d   = 1'b0;
                    winner_d      = 1'b0;
                    count_d       = '0;
                    state_d       = SERVE;
                end
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= SERVE;
            count_q       <= '0;
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            change_x_q    <= 1'b0;
            change_y_q    <= 2'b00;
            ball_reset_q  <= 1'b1;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
            lock_left_q   <= 1'b0;
            lock_right_q  <= 1'b0;
            scorer_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            change_x_q    <= change_x_d;
            change_y_q    <= change_y_d;
            ball_reset_q  <= ball_reset_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            lock_left_q   <= lock_left_d;
            lock_right_q  <= lock_right_d;
            scorer_q      <= scorer_d;
        end
    end

    assign changeXDirection = change_x_q;
    assign changeYDirection = change_y_q;
    assign ballReset        = ball_reset_q;
    assign scoreLeft        = score_left_q;
    assign scoreRight       = score_right_q;
    assign gameOver         = game_over_q;
    assign winner           = winner_q;
    assign debug_state      = state_q;

endmodule

// File: tb/tb_ball_collision_referee.sv
// Directed bench for ball_collision_referee with a short serve delay and a
// three-point game; each vector is one clock of inputs plus the outputs expected after it.
module tb_ball_collision_referee;

    localparam logic [1:0] ST_SERVE = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_GOAL  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    logic       clock = 1'b0;
    logic       reset;
    logic       startGame;
    logic [7:0] ballX;
    logic [8:0] ballY;
    logic       ballDirection;
    logic [8:0] leftPaddleY;
    logic [8:0] rightPaddleY;
    logic       changeXDirection;
    logic [1:0] changeYDirection;
    logic       ballReset;
    logic [3:0] scoreLeft;
    logic [3:0] scoreRight;
    logic       gameOver;
    logic       winner;
    logic [1:0] debug_state;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic       start;
        logic [7:0] x;
        logic [8:0] y;
        logic       dir;
        logic [8:0] lpy;
        logic [8:0] rpy;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    ball_collision_referee #(
        .SERVE_DELAY(4),
        .WIN_SCORE  (3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .startGame       (startGame),
        .ballX           (ballX),
        .ballY           (ballY),
        .ballDirection   (ballDirection),
        .leftPaddleY     (leftPaddleY),
        .rightPaddleY    (rightPaddleY),
        .changeXDirection(changeXDirection),
        .changeYDirection(changeYDirection),
        .ballReset       (ballReset),
        .scoreLeft       (scoreLeft),
        .scoreRight      (scoreRight),
        .gameOver        (gameOver),
        .winner          (winner),
        .debug_state     (debug_state)
    );

    always #5 clock = ~clock;

    // Expected outputs packed as {cx, cy[1:0], ballReset, scoreL, scoreR, gameOver, winner, state}.
    function automatic logic [15:0] ex(input logic cx, input logic [1:0] cy, input logic br,
                                       input logic [3:0] sl, input logic [3:0] sr,
                                       input logic go, input logic win, input logic [1:0] st);
        return {cx, cy, br, sl, sr, go, win, st};
    endfunction

    function automatic vec_t mk(input logic rst, input logic start, input logic [7:0] x,
                                input logic [8:0] y, input logic dir, input logic [8:0] lpy,
                                input logic [8:0] rpy, input logic [15:0] e);
        vec_t v;
        v.rst = rst; v.start = start; v.x = x; v.y = y; v.dir = dir;
        v.lpy = lpy; v.rpy = rpy; v.exp = e;
        return v;
    endfunction

    // Ball mid-field moving left with both paddles far away: nothing should happen.
    function automatic vec_t idle(input logic rst, input logic start, input logic [15:0] e);
        return mk(rst, start, 8'd120, 9'd0, 1'b0, 9'd300, 9'd300, e);
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [15:0] got;
        logic [15:0] want;
        reset         = v.rst;
        startGame     = v.start;
        ballX         = v.x;
        ballY         = v.y;
        ballDirection = v.dir;
        leftPaddleY   = v.lpy;
        rightPaddleY  = v.rpy;
        exp_q.push_back(v.exp);
        @(posedge clock);
        #1;
        got  = {changeXDirection, changeYDirection, ballReset, scoreLeft, scoreRight,
                gameOver, winner, debug_state};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h (cx=%b cy=%b br=%b sl=%0d sr=%0d go=%b win=%b st=%0d) expected=%h",
                     name, got, got[15], got[14:13], got[12], got[11:8], got[7:4],
                     got[3], got[2], got[1:0], want);
        end
    endtask

    initial begin
        reset = 1'b1; startGame = 1'b0; ballX = 8'd120; ballY = 9'd0;
        ballDirection = 1'b0; leftPaddleY = 9'd300; rightPaddleY = 9'd300;
        @(posedge clock);
        #1;

        // Reset, serve timing, left top hit with lockout, right bottom hit, miss, goals.
        tbl.push_back(idle(1'b1, 1'b0, ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, ST_SERVE)));
        tbl.push_back(idle(1'b1, 1'b0, ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, ST_SERVE)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, ST_SERVE)));
        tbl.push_back(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ST_PLAY)));
        tbl.push_back(mk(1'b0, 1'b0, 8'd28, 9'd105, 1'b0, 9'd100, 9'd300,
                         ex(1'b1, 2'b10, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ST_PLAY)));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b0, 1'b0, 8'd28, 9'd105, 1'b0, 9'd100, 9'd300,
                             ex(1'b0, 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ST_PLAY)));
        tbl.push_back(mk(1'b0, 1'b0, 8'd120, 9'd105, 1'b1, 9'd100, 9'd300,
                         ex(1'b0, 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ST_PLAY)));
        tbl.push_back(mk(1'b0, 1'b0, 8'd28, 9'd105, 1'b0, 9'd100, 9'd300,
                         ex(1'b1, 2'b10, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ST_PLAY)));
        tbl.push_back(mk(1'b0, 1'b0, 8'd212, 9'd135, 1'b1, 9'd300, 9'd100,
                         ex(1'b1, 2'b01, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ST_PLAY)));
        tbl.push_back(mk(1'b0, 1'b0, 8'd212, 9'd135, 1'b1, 9'd300, 9'd100,
                         ex(1'b0, 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ST_PLAY)));
        tbl.push_back(mk(1'b0, 1'b0, 8'd28, 9'd200, 1'b0, 9'd100, 9'd300,
                         ex(1'b0, 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ST_PLAY)));
        tbl.push_back(mk(1'b0, 1'b0, 8'd4, 9'd200, 1'b0, 9'd100, 9'd300,
                         ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, ST_GOAL)));
        tbl.push_back(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, ST_SERVE)));
        tbl.push_back(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, ST_SERVE)));
        tbl.push_back(idle(1'b0, 1'b1, ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, ST_SERVE)));
        tbl.push_back(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, ST_SERVE)));
        tbl.push_back(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, ST_PLAY)));
        tbl.push_back(mk(1'b0, 1'b0, 8'd250, 9'd0, 1'b0, 9'd300, 9'd300,
                         ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, ST_GOAL)));
        for (int i = 0; i < 4; i++)
            tbl.push_back(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0, ST_SERVE)));
        tbl.push_back(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, ST_PLAY)));

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Third right goal ends the game; goal and hit stimulus afterwards is ignored.
        apply(mk(1'b0, 1'b0, 8'd3, 9'd0, 1'b0, 9'd300, 9'd300,
                 ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0, ST_GOAL)), "goal3");
        apply(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd3, 1'b1, 1'b1, ST_OVER)), "game_over");
        for (int i = 0; i < 2; i++)
            apply(mk(1'b0, 1'b0, 8'd3, 9'd0, 1'b0, 9'd300, 9'd300,
                     ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd3, 1'b1, 1'b1, ST_OVER)), "over_goal_ign");
        for (int i = 0; i < 2; i++)
            apply(mk(1'b0, 1'b0, 8'd28, 9'd105, 1'b0, 9'd100, 9'd300,
                     ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd3, 1'b1, 1'b1, ST_OVER)), "over_hit_ign");
        apply(idle(1'b0, 1'b1, ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, ST_SERVE)), "start_game");
        for (int i = 0; i < 3; i++)
            apply(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, ST_SERVE)), "reserve");
        apply(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, ST_PLAY)), "replay");

        // Left player scores on the right goal line, then reset lands on a hit cycle.
        apply(mk(1'b0, 1'b0, 8'd236, 9'd0, 1'b1, 9'd300, 9'd300,
                 ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, ST_GOAL)), "right_goal");
        apply(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0, ST_SERVE)), "left_scores");
        for (int i = 0; i < 3; i++)
            apply(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0, ST_SERVE)), "serve_l");
        apply(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, ST_PLAY)), "play_l");
        apply(mk(1'b0, 1'b0, 8'd28, 9'd105, 1'b0, 9'd100, 9'd300,
                 ex(1'b1, 2'b10, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, ST_PLAY)), "hit_before_rst");
        apply(mk(1'b1, 1'b0, 8'd28, 9'd105, 1'b0, 9'd100, 9'd300,
                 ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, ST_SERVE)), "reset_on_hit");
        apply(idle(1'b0, 1'b0, ex(1'b0, 2'b00, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, ST_SERVE)), "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
